uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` serializer among N byte requesters. It sits between client logic (register interface, debug streamer, protocol engines) and the `uart_tx` instance. It picks one pending requester, loads its byte onto `wdata`, issues a toggle-encoded `push`, and tracks the serializer's `empty` flag until the frame completes. It also provides abort (`clear`) and a stall timeout.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `IMSB`, 1: MSB of requester index; must satisfy 2^(IMSB+1) ≥ N.
- `TMSB`, 7: MSB of the start-timeout counter.

Ports:
- `clk`  in  1  single system clock; all logic is on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester level request; held until acked.
- `req_data`  in  8*N  byte for requester i on `[8*i+7:8*i]`.
- `ack`  out  N  one-cycle pulse to the granted requester; `req` may drop the following cycle.
- `abort`  in  1  synchronous abort request.
- `empty`  in  1  serializer-empty flag from `uart_tx`, asynchronous to `clk`.
- `push`  out  1  toggle to `uart_tx`; each edge requests one frame.
- `clear`  out  1  one-cycle clear pulse to `uart_tx`.
- `wdata`  out  8  byte to `uart_tx`; stable from push until the next grant.
- `busy`  out  1  high whenever state ≠ IDLE.
- `owner`  out  IMSB+1  index of the current or last grantee.
- `tmo_err`  out  1  sticky start-timeout flag; cleared by `abort`.

## Operation
- `empty` passes through a 2-flop synchronizer to produce `empty_s`. The reset value of both flops is 1.
- Round-robin pointer `ptr`, reset 0. The grant goes to the first set `req[i]` searching `ptr, ptr+1, … N-1, 0, …` with modulo-N wrap. After a completed frame, `ptr` becomes grantee+1 mod N.

State machine:
- **IDLE.** If `|req` and `empty_s`, then in one cycle:
  - latch `wdata ← req_data[winner]`,
  - set `owner ← winner`,
  - pulse `ack[winner]`,
  - toggle `push`,
  - clear the timeout counter,
  - go to START.
- **START.** Wait for `empty_s`=0, meaning the engine accepted the frame; then go to DONE. The counter increments each cycle. On reaching all-ones: set `tmo_err`, pulse `clear`, advance `ptr`, go to IDLE.
- **DONE.** Wait for `empty_s`=1, then advance `ptr` and go to IDLE.

Abort and special cases:
- `abort` has the highest priority in any state: pulse `clear`, clear `tmo_err`, go to IDLE. `ptr` is unchanged and no `ack` is issued that cycle.
- `abort` while IDLE still pulses `clear`.
- A requester dropping `req` before it is granted is simply skipped.

Reset values:
- `push`=0, `clear`=0, `ack`=0, `wdata`=0, `owner`=0, `busy`=0, `tmo_err`=0, state IDLE.

## Timing
- All outputs are registered.
- Request to grant: `ack`, `push` edge and `wdata` update all occur on the first clock edge where IDLE sees `req` and `empty_s`=1.
- `wdata` changes on the same edge as `push`. The serializer samples it after its own synchronization of `push`, so `wdata` is held stable through START and DONE.
- Grant-to-grant minimum: 1 (grant) + ≥2 (START sync latency) + frame time + 2 (DONE sync) cycles. No back-to-back push without an intervening empty=1.
- If `empty_s`=0 in IDLE (engine still draining after an abort), no grant is made until it returns to 1.
- `abort` in the same cycle as a would-be grant: abort wins, and there is no push toggle and no ack.
- Timeout fires after 2^(TMSB+1)-1 cycles in START.
- Reset mid-frame returns to reset values immediately. `push` returning to 0 may itself look like a toggle; the system resets `uart_tx` with the same `rstn`.

## Structure
- Shared package `lsrt_uart_pkg`: state encoding constants (IDLE=2'd0, START=2'd1, DONE=2'd2) and the default `N`/`TMSB` values, reused by a future `uart_rx` dispatcher.
- One natural sub-module, `rr_pick`: combinational round-robin priority encoder with inputs `req` and `ptr`, outputs `winner` and `hit`. It is reusable by other lsrt arbiters.
- The 2-flop synchronizer stays inline.

## Test plan
- **Single request.** `req`=4'b0100, `req_data[23:16]`=8'hA5, `empty` idle high.
  - `ack`=4'b0100 for 1 cycle, `push` toggles once, `wdata`=8'hA5, `owner`=2.
  - Model drops `empty` 3 cycles later, raises it 100 cycles later; `busy` falls 2 cycles after `empty` rises.
- **Fairness.** All four `req` held high with bytes 8'h10, 8'h11, 8'h12, 8'h13.
  - Grant order is 0, 1, 2, 3, 0 and `wdata` follows the same sequence.
  - Exactly one `push` toggle per frame.
- **Wrap.** `ptr`=3, `req`=4'b0011 → grant 0, then 1.
- **Timeout.** Model never lowers `empty` after `push`, with `TMSB`=3.
  - `tmo_err`=1 and a `clear` pulse exactly 15 cycles after entering START; state returns to IDLE.
  - A subsequent `abort` clears `tmo_err`.
- **Abort mid-frame.** Assert `abort` in DONE.
  - `clear` pulses 1 cycle, state goes to IDLE, no `ack`, `ptr` is unchanged.
  - Same-cycle abort and request produce no `push` toggle.
- **Reset mid-frame.** Pulse `rstn` low in START.
  - All outputs return to reset values asynchronously.
  - After release, `empty_s` reads 1 within 2 cycles and the first grant goes to requester 0.

Source files
------------

// File: rtl/lsrt_uart_pkg.sv
// ---------------------------------------------------------------------------
// lsrt_uart_pkg
//   Shared definitions for the lsrt UART arbitration/dispatch blocks.
//   - arb_state_e : arbiter FSM state encoding (IDLE/START/DONE)
//   - ARB_N_DEFAULT / ARB_TMSB_DEFAULT : default requester count and
//     start-timeout counter MSB
// ---------------------------------------------------------------------------
package lsrt_uart_pkg;

    localparam int unsigned ARB_N_DEFAULT    = 4;
    localparam int unsigned ARB_TMSB_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

endpackage : lsrt_uart_pkg

// File: rtl/uart_tx_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority encoder. Searches req starting at
//   index ptr, then ptr+1 ... N-1, 0 ... with modulo-N wrap, and reports
//   the first set bit.
// Ports:
//   req    in  N       request vector
//   ptr    in  IMSB+1  search start index (expected < N)
//   winner out IMSB+1  index of the first set request found
//   hit    out 1       at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
    import lsrt_uart_pkg::*;
#(
    parameter int unsigned N    = ARB_N_DEFAULT,
    parameter int unsigned IMSB = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IMSB:0] ptr,
    output logic [IMSB:0] winner,
    output logic          hit
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = IMSB + 1;

    always_comb begin
        winner = '0;
        hit    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!hit && req[SW'((32'(ptr) + k) % N)]) begin
                hit    = 1'b1;
                winner = IW'((32'(ptr) + k) % N);
            end
        end
    end

endmodule : rr_pick

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Round-robin arbiter sharing one uart_tx serializer among N byte
//   requesters. A grant latches the winner's byte onto wdata, pulses its ack
//   and toggles push; the FSM then follows the serializer's empty flag
//   (START: wait for acceptance, DONE: wait for drain). Provides abort
//   (clear pulse) and a sticky start timeout.
// Ports:
//   clk      in  1       system clock (posedge)
//   rstn     in  1       asynchronous active-low reset
//   req      in  N       per-requester level request, held until acked
//   req_data in  8*N     byte of requester i on [8*i+7:8*i]
//   ack      out N       one-cycle pulse to the granted requester
//   abort    in  1       synchronous abort, highest priority
//   empty    in  1       serializer empty flag (asynchronous to clk)
//   push     out 1       toggle; each edge requests one frame
//   clear    out 1       one-cycle clear pulse to the serializer
//   wdata    out 8       granted byte, stable from push to next grant
//   busy     out 1       high whenever the FSM is not IDLE
//   owner    out IMSB+1  index of the current or last grantee
//   tmo_err  out 1       sticky start-timeout flag, cleared by abort
// ---------------------------------------------------------------------------
module uart_tx_arb
    import lsrt_uart_pkg::*;
#(
    parameter int unsigned N    = ARB_N_DEFAULT,
    parameter int unsigned IMSB = 1,
    parameter int unsigned TMSB = ARB_TMSB_DEFAULT
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   ack,
    input  logic           abort,
    input  logic           empty,
    output logic           push,
    output logic           clear,
    output logic [7:0]     wdata,
    output logic           busy,
    output logic [IMSB:0]  owner,
    output logic           tmo_err
);

    localparam int unsigned IW = IMSB + 1;
    localparam int unsigned CW = TMSB + 1;

    arb_state_e     state_q, state_d;
    logic           empty_meta_q, empty_s_q;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           push_q, push_d;
    logic           clear_q, clear_d;
    logic           tmo_q, tmo_d;
    logic           busy_q;
    logic [N-1:0]   ack_q, ack_d;
    logic [7:0]     wdata_q, wdata_d;

    logic [IW-1:0]  winner;
    logic           hit;
    logic [7:0]     win_byte;
    logic [N-1:0]   grant_vec;
    logic [IW-1:0]  ptr_after;

    // Two-flop synchronizer; resets to "empty" so the first grant after
    // reset is not delayed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            empty_meta_q <= 1'b1;
            empty_s_q    <= 1'b1;
        end else begin
            empty_meta_q <= empty;
            empty_s_q    <= empty_meta_q;
        end
    end

    rr_pick #(
        .N    (N),
        .IMSB (IMSB)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .hit    (hit)
    );

    always_comb begin
        win_byte  = '0;
        grant_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner == IW'(i)) begin
                win_byte     = req_data[8*i +: 8];
                grant_vec[i] = 1'b1;
            end
        end
    end

    // Pointer moves past the grantee once its frame ends (done or timed out).
    assign ptr_after = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        push_d  = push_q;
        clear_d = 1'b0;
        tmo_d   = tmo_q;
        ack_d   = '0;
        wdata_d = wdata_q;

        if (abort) begin
            clear_d = 1'b1;
            tmo_d   = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit && empty_s_q) begin
                        wdata_d = win_byte;
                        owner_d = winner;
                        ack_d   = grant_vec;
                        push_d  = ~push_q;
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (!empty_s_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == '1) begin
                            tmo_d   = 1'b1;
                            clear_d = 1'b1;
                            ptr_d   = ptr_after;
                            state_d = IDLE;
                        end
                    end
                end
                DONE: begin
                    if (empty_s_q) begin
                        ptr_d   = ptr_after;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            push_q  <= 1'b0;
            clear_q <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            clear_q <= clear_d;
            tmo_q   <= tmo_d;
            busy_q  <= (state_d != IDLE);
            ack_q   <= ack_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack     = ack_q;
    assign push    = push_q;
    assign clear   = clear_q;
    assign wdata   = wdata_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign tmo_err = tmo_q;

endmodule : uart_tx_arb
